// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the prefetch FIFO and the fetch unit top level.
package fetch_pkg;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} words for the datapath.
// Head is read combinationally; flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count
                   + (AW + 1)'(do_push)
                   - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word reads, buffers them
// and hands {pc, instruction} to the datapath; redirects drain.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUTST  = FIFO_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    output logic        memReqValid,
    output logic [31:0] memReqAddr,
    input  logic        memReqReady,
    input  logic        memRespValid,
    input  logic [31:0] memRespData,
    input  logic        redirectValid,
    input  logic [31:0] redirectPC,
    output logic        instrValid,
    output logic [31:0] instrPC,
    output logic [31:0] instruction,
    input  logic        instrReady
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outst;
    logic [CW-1:0] discard;
    logic [CW-1:0] outst_next;
    logic [CW-1:0] discard_next;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [63:0]   fifo_head;

    logic          pop;
    logic          fifo_ok;
    logic          req_fire;
    logic          resp_drop;
    logic          resp_push;
    logic [CW:0]   credit_used;
    logic [31:0]   oldest_pc;

    assign instrValid  = !fifo_empty;
    assign instrPC     = fifo_head[63:32];
    assign instruction = fifo_head[31:0];
    assign pop         = instrValid && instrReady;

    // A head popped this cycle frees its slot before any new word lands.
    assign fifo_ok     = !fifo_full || pop;
    assign credit_used = {1'b0, outst}
                       + {1'b0, fifo_count}
                       - (CW + 1)'(pop);

    assign memReqValid = reset
                      && (state == FETCH)
                      && !redirectValid
                      && fifo_ok
                      && (credit_used < (CW + 1)'(FIFO_DEPTH))
                      && (outst < CW'(MAX_OUTST));
    assign memReqAddr  = fetch_pc;
    assign req_fire    = memReqValid && memReqReady;

    assign resp_drop = memRespValid && (discard != '0);
    assign resp_push = memRespValid
                    && (discard == '0)
                    && (outst != '0);

    // Responses are in order, so the oldest PC is implied by the count.
    assign oldest_pc = fetch_pc - (32'(outst) << 2);

    assign outst_next = outst
                      + CW'(req_fire)
                      - CW'(resp_drop || resp_push);

    // Every request still in flight belongs to the abandoned path.
    assign discard_next = redirectValid
                        ? outst_next
                        : discard - CW'(resp_drop);

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (resp_push),
        .push_data ({oldest_pc, memRespData}),
        .pop       (pop),
        .flush     (redirectValid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
        end else begin
            outst   <= outst_next;
            discard <= discard_next;
            if (redirectValid) begin
                fetch_pc <= redirectPC & ~32'h3;
                state    <= (discard_next != '0)
                          ? DRAIN : FETCH;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + INSTR_BYTES;
                end
                unique case (state)
                    FETCH: state <= FETCH;
                    DRAIN: begin
                        if (discard_next == '0) begin
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model plus a scoreboard
// of expected {pc, word} pairs checked at each head handshake.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        memReqValid;
    logic [31:0] memReqAddr;
    logic        memReqReady = 1'b1;
    logic        memRespValid = 1'b0;
    logic [31:0] memRespData = '0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPC = '0;
    logic        instrValid;
    logic [31:0] instrPC;
    logic [31:0] instruction;
    logic        instrReady = 1'b1;

    always #5 clock = ~clock;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .memReqValid   (memReqValid),
        .memReqAddr    (memReqAddr),
        .memReqReady   (memReqReady),
        .memRespValid  (memRespValid),
        .memRespData   (memRespData),
        .redirectValid (redirectValid),
        .redirectPC    (redirectPC),
        .instrValid    (instrValid),
        .instrPC       (instrPC),
        .instruction   (instruction),
        .instrReady    (instrReady)
    );

    // kind: 0 live, 1 abandoned by redirect, 2 orphaned by reset
    typedef struct {
        logic [31:0] addr;
        logic [31:0] eaddr;
        int          due;
        int          kind;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ins_t;

    req_t        pend[$];
    ins_t        exp_q[$];
    logic [31:0] fire_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int fires = 0;
    int hs_cnt = 0;

    logic        rst_ctl = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        rdy = 1'b1;
    logic        mrdy = 1'b1;
    logic [31:0] exp_pc = '0;

    logic        s_req;
    logic        s_fire;
    logic        s_iv;
    logic        s_hs;
    logic [31:0] s_addr;
    logic [31:0] s_ipc;
    logic [31:0] s_word;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        int   outst;
        int   stale;
        bit   pres;
        bit   pop_now;
        bit   erv;
        req_t pe;
        ins_t e;
        outst = 0;
        stale = 0;
        pres  = 0;
        if (!rst_ctl) begin
            foreach (pend[i]) pend[i].kind = 2;
            exp_q.delete();
            exp_pc = 32'h0;
        end
        foreach (pend[i]) begin
            if (pend[i].kind != 2) outst++;
            if (pend[i].kind == 1) stale++;
        end
        reset         = rst_ctl;
        redirectValid = redir;
        redirectPC    = redir_pc;
        instrReady    = rdy;
        memReqReady   = mrdy;
        memRespValid  = 1'b0;
        memRespData   = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            pe           = pend.pop_front();
            pres         = 1;
            memRespValid = 1'b1;
            memRespData  = mem_word(pe.addr);
        end
        #1;
        pop_now = rdy && exp_q.size() > 0;
        erv = rst_ctl && !redir && stale == 0
           && (outst + exp_q.size() - int'(pop_now) < DEPTH)
           && outst < DEPTH;
        check("req_valid", 32'(memReqValid), 32'(erv));
        if (erv) check("req_addr", memReqAddr, exp_pc);
        check("instr_valid", 32'(instrValid),
              32'(exp_q.size() > 0));
        if (!rst_ctl) begin
            check("rst_addr", memReqAddr, 32'h0);
            check("rst_pc", instrPC, 32'h0);
            check("rst_instr", instruction, 32'h0);
        end
        s_hs = 0;
        if (instrValid && instrReady && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("head_pc", instrPC, e.pc);
            check("head_word", instruction, e.word);
            s_hs   = 1;
            s_ipc  = instrPC;
            s_word = instruction;
            hs_cnt++;
        end
        s_req  = memReqValid;
        s_addr = memReqAddr;
        s_iv   = instrValid;
        s_fire = memReqValid && memReqReady;
        if (s_fire) begin
            pend.push_back('{memReqAddr, exp_pc, cyc + lat, 0});
            fire_log.push_back(memReqAddr);
            exp_pc = exp_pc + 32'd4;
            fires++;
        end
        if (pres && pe.kind == 0 && !redir)
            exp_q.push_back('{pe.eaddr, mem_word(pe.eaddr)});
        if (redir) begin
            exp_q.delete();
            foreach (pend[i])
                if (pend[i].kind == 0) pend[i].kind = 1;
            exp_pc = redir_pc & ~32'h3;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit          got;
        int          at;
        logic [31:0] first;

        // In-order stream after reset, no bubbles.
        run(3);
        rst_ctl = 1;
        hs_cnt  = 0;
        fire_log.delete();
        run(8);
        check("t1_hs_count", 32'(hs_cnt), 32'd6);
        check("t1_req0", fire_log[0], 32'h0);
        check("t1_req1", fire_log[1], 32'h4);
        check("t1_req2", fire_log[2], 32'h8);

        // Back-pressure caps requests at the FIFO depth.
        rst_ctl = 0;
        run(4);
        rdy     = 0;
        rst_ctl = 1;
        fires   = 0;
        run(10);
        check("t2_fires", 32'(fires), 32'd2);
        check("t2_idle", 32'(s_req), 32'd0);
        rdy = 1;
        run(1);
        check("t2_head", s_ipc, 32'h0);
        check("t2_resume_v", 32'(s_fire), 32'd1);
        check("t2_resume_a", s_addr, 32'h8);

        // Redirect with two requests in flight on slow memory.
        rst_ctl = 0;
        run(4);
        lat     = 3;
        rst_ctl = 1;
        run(2);
        redir    = 1;
        redir_pc = 32'h0000_0103;
        run(1);
        redir = 0;
        got   = 0;
        at    = -1;
        first = '1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_fire && !got) begin
                got   = 1;
                at    = i;
                first = s_addr;
            end
        end
        check("t3_first_at", 32'(at), 32'd2);
        check("t3_first_addr", first, 32'h100);
        rst_ctl = 0;
        run(4);
        rst_ctl = 1;
        got     = 0;
        first   = '1;
        run(2);
        redir    = 1;
        redir_pc = 32'h0000_0103;
        run(1);
        redir = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (s_hs) begin
                got   = 1;
                first = s_ipc;
            end
        end
        check("t3_hs_seen", 32'(got), 32'd1);
        check("t3_first_pc", first, 32'h100);

        // Second redirect while draining.
        rst_ctl = 0;
        run(4);
        rst_ctl = 1;
        run(2);
        redir    = 1;
        redir_pc = 32'h0000_0103;
        run(1);
        redir_pc = 32'h0000_0202;
        run(1);
        redir = 0;
        got   = 0;
        at    = -1;
        first = '1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_fire && !got) begin
                got   = 1;
                at    = i;
                first = s_addr;
            end
        end
        check("t3b_first_at", 32'(at), 32'd1);
        check("t3b_first_addr", first, 32'h200);

        // Redirect on the same cycle the head at 0x10 is taken.
        rst_ctl = 0;
        run(4);
        lat     = 1;
        rst_ctl = 1;
        run(6);
        redir    = 1;
        redir_pc = 32'h0000_0040;
        run(1);
        redir = 0;
        check("t4_hs", 32'(s_hs), 32'd1);
        check("t4_hs_pc", s_ipc, 32'h10);
        run(1);
        check("t4_empty", 32'(s_iv), 32'd0);
        check("t4_req_v", 32'(s_req), 32'd1);
        check("t4_req_a", s_addr, 32'h40);

        // Address wrap at the top of memory.
        rst_ctl = 0;
        run(4);
        rst_ctl  = 1;
        redir    = 1;
        redir_pc = 32'hFFFF_FFF8;
        run(1);
        redir = 0;
        fire_log.delete();
        run(3);
        check("t5_count", 32'(fire_log.size()), 32'd3);
        check("t5_req0", fire_log[0], 32'hFFFF_FFF8);
        check("t5_req1", fire_log[1], 32'hFFFF_FFFC);
        check("t5_req2", fire_log[2], 32'h0000_0000);

        // Reset mid-burst; stale responses must be ignored.
        rst_ctl = 0;
        run(4);
        lat     = 3;
        rst_ctl = 1;
        run(2);
        rst_ctl = 0;
        run(1);
        check("t6_req_off", 32'(s_req), 32'd0);
        check("t6_iv_off", 32'(s_iv), 32'd0);
        rst_ctl = 1;
        mrdy    = 0;
        run(2);
        check("t6_no_instr", 32'(s_iv), 32'd0);
        mrdy = 1;
        run(1);
        check("t6_restart_v", 32'(s_fire), 32'd1);
        check("t6_restart_a", s_addr, 32'h0);
        got   = 0;
        first = '1;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle();
            if (s_hs) begin
                got   = 1;
                first = s_word;
            end
        end
        check("t6_hs_seen", 32'(got), 32'd1);
        check("t6_word", first, mem_word(32'h0));

        // Random traffic against the scoreboard.
        lat = 2;
        for (int i = 0; i < 400; i++) begin
            rdy      = ($urandom_range(0, 3) != 0);
            mrdy     = ($urandom_range(0, 3) != 0);
            redir    = ($urandom_range(0, 19) == 0);
            redir_pc = $urandom;
            cycle();
        end
        redir = 0;
        rdy   = 1;
        mrdy  = 1;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
